// File: rtl/ph_cache_pkg.sv
// Shared types and helpers for the pulse-height frame cache.
package ph_cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HEADER,
    PIXELS,
    TS,
    DROP,
    HOST
  } state_e;

  localparam int CNT_W = 16;

  // Mask keeping the low pix_w bits of a 16-bit pixel half.
  function automatic logic [15:0] pix_mask(input int pix_w);
    logic [16:0] m;
    m = (17'd1 << pix_w) - 17'd1;
    return m[15:0];
  endfunction

endpackage

// File: rtl/ph_frame_cache_if.sv
// Stream handshake from the MAROC data-collection path into the frame cache.
interface ph_frame_cache_if;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tlast;
  logic        s_tready;

  modport master (output s_tdata, output s_tvalid, output s_tlast, input s_tready);
  modport slave  (input s_tdata, input s_tvalid, input s_tlast, output s_tready);
endinterface

// File: rtl/ph_cache_bank.sv
// One frame bank: 32-bit word writes, two registered 16-bit pixel read ports.
module ph_cache_bank #(
  parameter int NUM_PIX = 256,
  parameter int AW      = $clog2(NUM_PIX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-2:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          a_en,
  input  logic [AW-1:0] a_addr,
  output logic [15:0]   a_data,
  input  logic          b_en,
  input  logic [AW-1:0] b_addr,
  output logic [15:0]   b_data
);

  logic [31:0] mem [NUM_PIX/2];
  logic [31:0] a_word, b_word;
  logic        a_hi, b_hi;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Read registers hold their value while the port is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_word <= '0;
      a_hi   <= 1'b0;
      b_word <= '0;
      b_hi   <= 1'b0;
    end else begin
      if (a_en) begin
        a_word <= mem[a_addr[AW-1:1]];
        a_hi   <= a_addr[0];
      end
      if (b_en) begin
        b_word <= mem[b_addr[AW-1:1]];
        b_hi   <= b_addr[0];
      end
    end
  end

  assign a_data = a_hi ? a_word[31:16] : a_word[15:0];
  assign b_data = b_hi ? b_word[31:16] : b_word[15:0];

endmodule

// File: rtl/ph_frame_cache.sv
// Ping-pong PH frame cache: strips header, stores masked pixels, publishes frame + timestamp.
// Define PH_CACHE_STATS_EN to enable the err_cnt/drop_cnt counters (tied to 0 otherwise).
module ph_frame_cache
  import ph_cache_pkg::*;
#(
  parameter int NUM_PIX   = 256,
  parameter int HDR_WORDS = 20,
  parameter int PIX_W     = 12,
  parameter int TS_W      = 29,
  parameter int AW        = $clog2(NUM_PIX)
) (
  input  logic             clk,
  input  logic             rst,
  ph_frame_cache_if.slave  s,
  output logic             frame_valid,
  input  logic             frame_ack,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [15:0]      rd_data,
  input  logic             host_req,
  input  logic             host_sel,
  input  logic [AW-1:0]    host_addr,
  output logic [15:0]      host_data,
  output logic [TS_W-1:0]  elapsed_time,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int          WORDS    = NUM_PIX / 2;
  localparam logic [15:0] MASK     = pix_mask(PIX_W);
  localparam logic [15:0] HDR_LAST = 16'(HDR_WORDS - 1);
  localparam logic [15:0] PIX_LAST = 16'(WORDS - 1);

  state_e         state_q, state_d;
  logic [15:0]    cnt_q;
  logic           wr_bank_q, rd_bank_q, host_bank_q;
  logic           beat, pix_we, publish, collide, malformed, leave_host;
  logic [AW-2:0]  pix_waddr;
  logic [31:0]    pix_wdata;
  logic [15:0]    a_data [2];
  logic [15:0]    b_data [2];

  assign beat = s.s_tvalid & s.s_tready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (s.s_tlast)           state_d = IDLE;
          else if (HDR_WORDS <= 1) state_d = PIXELS;
          else                     state_d = HEADER;
        end else if (host_req) begin
          state_d = HOST;
        end
      end
      HEADER: if (beat) state_d = s.s_tlast ? IDLE : ((cnt_q == HDR_LAST) ? PIXELS : HEADER);
      PIXELS: if (beat) state_d = s.s_tlast ? IDLE : ((cnt_q == PIX_LAST) ? TS : PIXELS);
      TS:     if (beat) state_d = s.s_tlast ? IDLE : DROP;
      DROP:   if (beat && s.s_tlast) state_d = IDLE;
      HOST:   if (!host_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // With no header the IDLE beat is already pixel word 0.
  always_comb begin
    s.s_tready = (state_q != HOST);
    pix_we     = beat && ((state_q == PIXELS) || (state_q == IDLE && HDR_WORDS == 0));
    pix_waddr  = (state_q == PIXELS) ? cnt_q[AW-2:0] : '0;
    publish    = beat && (state_q == TS) && s.s_tlast && !frame_valid;
    collide    = beat && (state_q == TS) && s.s_tlast && frame_valid;
    malformed  = beat && (((state_q == IDLE || state_q == HEADER || state_q == PIXELS) && s.s_tlast) ||
                          ((state_q == TS) && !s.s_tlast));
    leave_host = (state_q == HOST) && !host_req;
  end

  assign pix_wdata = {s.s_tdata[31:16] & MASK, s.s_tdata[15:0] & MASK};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (beat) begin
      case (state_q)
        IDLE:    cnt_q <= (HDR_WORDS == 1) ? 16'd0 : 16'd1;
        HEADER:  cnt_q <= (cnt_q == HDR_LAST) ? 16'd0 : cnt_q + 16'd1;
        PIXELS:  cnt_q <= cnt_q + 16'd1;
        default: cnt_q <= '0;
      endcase
    end
  end

  // Published bank is always the one not being written.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q    <= 1'b0;
      frame_valid  <= 1'b0;
      elapsed_time <= '0;
    end else if (publish) begin
      wr_bank_q    <= ~wr_bank_q;
      frame_valid  <= 1'b1;
      elapsed_time <= s.s_tdata[TS_W-1:0];
    end else if (leave_host || frame_ack) begin
      frame_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_bank_q   <= 1'b0;
      host_bank_q <= 1'b0;
    end else begin
      if (rd_en)    rd_bank_q   <= ~wr_bank_q;
      if (host_req) host_bank_q <= host_sel;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    ph_cache_bank #(.NUM_PIX(NUM_PIX), .AW(AW)) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (pix_we && (wr_bank_q == 1'(b))),
      .waddr  (pix_waddr),
      .wdata  (pix_wdata),
      .a_en   (rd_en),
      .a_addr (rd_addr),
      .a_data (a_data[b]),
      .b_en   (host_req),
      .b_addr (host_addr),
      .b_data (b_data[b])
    );
  end

  assign rd_data   = a_data[rd_bank_q];
  assign host_data = b_data[host_bank_q];

`ifdef PH_CACHE_STATS_EN
  logic [CNT_W-1:0] err_q, drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= '0;
      drop_q <= '0;
    end else begin
      if (malformed && err_q != '1) err_q  <= err_q + 1'b1;
      if (collide && drop_q != '1)  drop_q <= drop_q + 1'b1;
    end
  end

  assign err_cnt  = err_q;
  assign drop_cnt = drop_q;
`else
  logic unused_stats;
  assign unused_stats = malformed ^ collide;
  assign err_cnt      = '0;
  assign drop_cnt     = '0;
`endif

endmodule
